main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameters SHALL be none; all encodings SHALL come from the shared package.
REQ-002 Clocking and reset SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 op  in  7  opcode field of the instruction register.
REQ-006 Zero  in  1  ALU zero flag.
REQ-007 MemReady  in  1  memory completes the current request this cycle.
REQ-008 MemReq  out  1  memory access request, held until MemReady.
REQ-009 MemWrite  out  1  store qualifier, valid only with MemReq.
REQ-010 AdrSrc  out  1  0 = PC, 1 = ALU result register.
REQ-011 IRWrite  out  1  load the instruction register.
REQ-012 PCWrite  out  1  load PC (PCUpdate | (Branch & Zero)).
REQ-013 RegWrite  out  1  register file write enable.
REQ-014 ALUSrcA  out  2  00 PC, 01 oldPC, 10 rs1 register.
REQ-015 ALUSrcB  out  2  00 rs2 register, 01 immediate, 10 constant 4.
REQ-016 ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result.
REQ-017 ALUOP  out  2  00 R-type, 01 I-arith, 10 add, 11 sub; feeds the ALU decoder.
REQ-018 InstrDone  out  1  one-cycle pulse when an instruction retires.
REQ-019 Illegal  out  1  sticky unsupported-opcode flag.

Function
REQ-020 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ERROR.
REQ-021 FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOP=10, ResultSrc=10; IRWrite=PCUpdate=MemReady; stay until MemReady=1, then DECODE.
REQ-022 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOP=10 (branch target); next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL, other->ERROR.
REQ-023 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOP=10; next MEMREAD if op=0000011, else MEMWRITE.
REQ-024 MEMREAD: MemReq=1, AdrSrc=1; stay until MemReady, then MEMWB.
REQ-025 MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1; next FETCH.
REQ-026 MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1; stay until MemReady; InstrDone=MemReady; then FETCH.
REQ-027 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOP=00; EXECI: ALUSrcA=10, ALUSrcB=01, ALUOP=01; both next ALUWB.
REQ-028 ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1; next FETCH.
REQ-029 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOP=11, ResultSrc=00, Branch=1, InstrDone=1; next FETCH.
REQ-030 JAL: ALUSrcA=01, ALUSrcB=10, ALUOP=10, ResultSrc=00, PCUpdate=1, next ALUWB (InstrDone only in ALUWB).
REQ-031 ERROR: Illegal=1, all enables 0, MemReq=0; remain until reset.
REQ-032 Unlisted outputs SHALL be 0 in every state; outputs SHALL be combinational from state plus MemReady/Zero only.
REQ-033 MemReq SHALL never deassert while a request is pending; MemReady outside a MemReq state SHALL be ignored.
REQ-034 Worst-case latency: lw 5 cycles, sw/R/I/jal 4, beq 3, with zero memory wait.

Reset
REQ-035 rst_n low SHALL force state FETCH immediately, mid-access included; outputs then equal FETCH decoding with MemReady as driven.
REQ-036 Illegal SHALL clear only on reset; no other state is held.

Structure
REQ-037 State enum, opcode constants and ALUOP/ALUSrc/ResultSrc encodings SHALL live in a shared core package used with the ALU decoder.
REQ-038 No sub-module is required; state register and output decode stay in main_fsm.

Verification
REQ-039 Reset then op=0110011, MemReady=1 -> FETCH, DECODE, EXECR (ALUOP=00), ALUWB (RegWrite=1, InstrDone=1), FETCH.
REQ-040 op=0000011, MemReady low 3 cycles in MEMREAD -> MemReq/AdrSrc held 4 cycles, then MEMWB with ResultSrc=01.
REQ-041 op=1100011, Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; ALUOP=11 both cases.
REQ-042 op=1111111 -> ERROR, Illegal=1 sticky for 20 cycles; rst_n pulse returns to FETCH, Illegal=0.
REQ-043 rst_n low during MEMWRITE wait -> MemWrite drops asynchronously; next state FETCH.

Source files
------------

// File: rtl/main_fsm_pkg.sv
// Shared core package: FSM state encoding, opcodes and datapath select encodings.
// Used by main_fsm and by the ALU decoder, which consumes the ALUOP encoding.
// Pure declarations, no logic.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd11
  } state_e;

  // Supported opcodes (instr[6:0])
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALUOP encoding seen by the ALU decoder
  localparam logic [1:0] ALUOP_RTYPE  = 2'b00;
  localparam logic [1:0] ALUOP_IARITH = 2'b01;
  localparam logic [1:0] ALUOP_ADD    = 2'b10;
  localparam logic [1:0] ALUOP_SUB    = 2'b11;

  // ALU A operand select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Control word produced by the output decoder; PCWrite is derived from
  // pc_update/branch together with the Zero flag.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  // Opcode dispatch out of DECODE; anything unsupported traps to ERROR.
  function automatic state_e decode_next(input logic [6:0] op);
    state_e nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_RTYPE:     nxt = S_EXECR;
      OP_ITYPE:     nxt = S_EXECI;
      OP_BEQ:       nxt = S_BEQ;
      OP_JAL:       nxt = S_JAL;
      default:      nxt = S_ERROR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM: sequences fetch/decode/execute/writeback.
// Outputs are combinational from state plus MemReady/Zero (Mealy on those two only).
// Memory waits hold the request state until MemReady; MemReady elsewhere is ignored.
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOP,
  output logic       InstrDone,
  output logic       Illegal
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;

  // State register; reset lands in FETCH at once, even mid memory access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; memory states only advance on MemReady, ERROR is terminal
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE:   state_d = decode_next(op);
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; every field not set by a state stays zero
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.ir_write   = MemReady;
        ctrl.pc_update  = MemReady;
      end
      S_DECODE: begin
        // Precompute branch target oldPC + imm
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_RDATA;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.instr_done = MemReady;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_IARITH;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        // Compare rs1 - rs2; ALUOut still holds the target from DECODE
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        // PC <= target from ALUOut while the ALU forms oldPC + 4 for rd
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      S_ERROR: begin
        ctrl.illegal = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign MemReq    = ctrl.mem_req;
  assign MemWrite  = ctrl.mem_write;
  assign AdrSrc    = ctrl.adr_src;
  assign IRWrite   = ctrl.ir_write;
  assign PCWrite   = ctrl.pc_update | (ctrl.branch & Zero);
  assign RegWrite  = ctrl.reg_write;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign ALUOP     = ctrl.alu_op;
  assign InstrDone = ctrl.instr_done;
  assign Illegal   = ctrl.illegal;

endmodule

// File: tb/tb_main_fsm.sv
// Directed table-driven bench for main_fsm.
// One vector per cycle: drive op/Zero/MemReady, compare all outputs, then clock.
// Hand sequences cover sticky ERROR and asynchronous reset mid-access.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       Zero;
  logic       MemReady;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOP;
  logic       InstrDone, Illegal;

  always #5 clk = ~clk;

  main_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOP     (ALUOP),
    .InstrDone (InstrDone),
    .Illegal   (Illegal)
  );

  // Output word: {MemReq,MemWrite,AdrSrc}_{IRWrite,PCWrite,RegWrite}_SrcA_SrcB_Res_ALUOP_{Done,Illegal}
  logic [15:0] act;
  assign act = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ALUSrcA, ALUSrcB, ResultSrc, ALUOP, InstrDone, Illegal};

  localparam logic [15:0] E_FETCH0 = 16'b100_000_00_10_10_10_00;
  localparam logic [15:0] E_FETCH1 = 16'b100_110_00_10_10_10_00;
  localparam logic [15:0] E_DEC    = 16'b000_000_01_01_00_10_00;
  localparam logic [15:0] E_EXECR  = 16'b000_000_10_00_00_00_00;
  localparam logic [15:0] E_EXECI  = 16'b000_000_10_01_00_01_00;
  localparam logic [15:0] E_ALUWB  = 16'b000_001_00_00_00_00_10;
  localparam logic [15:0] E_MEMADR = 16'b000_000_10_01_00_10_00;
  localparam logic [15:0] E_MR     = 16'b101_000_00_00_00_00_00;
  localparam logic [15:0] E_MEMWB  = 16'b000_001_00_00_01_00_10;
  localparam logic [15:0] E_MW0    = 16'b111_000_00_00_00_00_00;
  localparam logic [15:0] E_MW1    = 16'b111_000_00_00_00_00_10;
  localparam logic [15:0] E_BEQ1   = 16'b000_010_10_00_00_11_10;
  localparam logic [15:0] E_BEQ0   = 16'b000_000_10_00_00_11_10;
  localparam logic [15:0] E_JAL    = 16'b000_010_01_10_00_10_00;
  localparam logic [15:0] E_ERR    = 16'b000_000_00_00_00_00_01;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct {
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic [6:0] o, input logic z, input logic r,
                              input logic [15:0] e);
    vec_t v;
    v.op = o; v.zero = z; v.rdy = r; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge, compare 1 time unit later, advance to next negedge
  task automatic step(input string name, input logic [6:0] o, input logic z,
                      input logic r, input logic [15:0] e);
    op = o; Zero = z; MemReady = r;
    #1;
    check(name, e);
    @(negedge clk);
  endtask

  initial begin
    // R-type: FETCH, DECODE, EXECR, ALUWB; MemReady/Zero ignored where irrelevant
    add(RT, 0, 1, E_FETCH1); add(RT, 0, 1, E_DEC); add(RT, 1, 1, E_EXECR); add(RT, 1, 1, E_ALUWB);
    // I-type with a two-cycle fetch wait
    add(IT, 0, 0, E_FETCH0); add(IT, 0, 0, E_FETCH0); add(IT, 0, 1, E_FETCH1);
    add(IT, 0, 0, E_DEC); add(IT, 0, 0, E_EXECI); add(IT, 0, 0, E_ALUWB);
    // lw with MemReady low 3 cycles in MEMREAD: request held 4 cycles
    add(LW, 0, 1, E_FETCH1); add(LW, 0, 0, E_DEC); add(LW, 0, 0, E_MEMADR);
    add(LW, 0, 0, E_MR); add(LW, 0, 0, E_MR); add(LW, 0, 0, E_MR); add(LW, 0, 1, E_MR);
    add(LW, 0, 0, E_MEMWB);
    // sw with write wait
    add(SW, 0, 1, E_FETCH1); add(SW, 0, 1, E_DEC); add(SW, 0, 1, E_MEMADR);
    add(SW, 0, 0, E_MW0); add(SW, 0, 0, E_MW0); add(SW, 0, 1, E_MW1);
    // beq taken then not taken
    add(BQ, 0, 1, E_FETCH1); add(BQ, 1, 0, E_DEC); add(BQ, 1, 0, E_BEQ1);
    add(BQ, 0, 1, E_FETCH1); add(BQ, 0, 0, E_DEC); add(BQ, 0, 0, E_BEQ0);
    // jal: PCWrite in JAL regardless of Zero, done in ALUWB
    add(JL, 0, 1, E_FETCH1); add(JL, 0, 0, E_DEC); add(JL, 1, 1, E_JAL); add(JL, 0, 0, E_ALUWB);
    // unsupported opcode traps
    add(BAD, 0, 1, E_FETCH1); add(BAD, 0, 0, E_DEC); add(BAD, 0, 1, E_ERR); add(BAD, 1, 1, E_ERR);

    // Reset state, with MemReady low and high
    rst_n = 1'b0; op = '0; Zero = 1'b0; MemReady = 1'b0;
    #1;
    check("reset_rdy0", E_FETCH0);
    MemReady = 1'b1;
    #1;
    check("reset_rdy1", E_FETCH1);
    MemReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].op, vecs[i].zero, vecs[i].rdy, vecs[i].exp);
    end

    // ERROR is sticky whatever the inputs
    for (int k = 0; k < 20; k++) begin
      step($sformatf("sticky%0d", k), 7'($urandom_range(0, 127)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), E_ERR);
    end

    // Reset pulse leaves ERROR and clears Illegal
    op = RT; Zero = 1'b0; MemReady = 1'b0;
    rst_n = 1'b0;
    #1;
    check("err_reset", E_FETCH0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    step("err_after_reset", RT, 0, 0, E_FETCH0);

    // Reset during a MEMWRITE wait drops MemWrite without a clock edge
    step("sw2_fetch", SW, 0, 1, E_FETCH1);
    step("sw2_dec", SW, 0, 0, E_DEC);
    step("sw2_memadr", SW, 0, 0, E_MEMADR);
    op = SW; Zero = 1'b0; MemReady = 1'b0;
    #1;
    check("sw2_wait", E_MW0);
    rst_n = 1'b0;
    #1;
    check_bit("sw2_memwrite_async", MemWrite, 1'b0);
    check("sw2_reset_outputs", E_FETCH0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    step("sw2_after_reset", SW, 0, 0, E_FETCH0);
    step("sw2_refetch", RT, 0, 1, E_FETCH1);
    step("sw2_decode", RT, 0, 0, E_DEC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
